// File: rtl/ins_decode_pipe.sv
// Pipelined instruction decoder for the toy CPU: valid/ready intake, registered
// execute-stage controls, and a one-cycle bubble on stale ACC / index-register reads.
module ins_decode_pipe #(
    parameter  int unsigned DW   = 4,
    parameter  int unsigned NREG = 16,
    parameter  int unsigned CW   = 16,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW+3:0] INST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] ACC,
    output logic [AW-1:0] IR_ADDR,
    input  logic [DW-1:0] INDEX,
    output logic [DW-1:0] DATA1,
    output logic [DW-1:0] DATA2,
    output logic [3:0]    ALU_OP,
    output logic [AW-1:0] IW_ADDR,
    output logic          IS,
    output logic          AS,
    output logic          OUT_VALID,
    output logic          ERR,
    output logic [CW-1:0] INSN_CNT
);

    localparam int unsigned IW = DW + 4;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LDI   = 4'b0001;
    localparam logic [3:0] OP_LDX   = 4'b0010;
    localparam logic [3:0] OP_STX   = 4'b0011;
    localparam logic [3:0] OP_ADD_X = 4'b0100;
    localparam logic [3:0] OP_ADD_I = 4'b0101;
    localparam logic [3:0] OP_SUB_X = 4'b0110;
    localparam logic [3:0] OP_SUB_I = 4'b0111;
    localparam logic [3:0] OP_NOT_A = 4'b1000;
    localparam logic [3:0] OP_NOT_I = 4'b1001;
    localparam logic [3:0] OP_OR_X  = 4'b1010;
    localparam logic [3:0] OP_OR_I  = 4'b1011;
    localparam logic [3:0] OP_AND_X = 4'b1100;
    localparam logic [3:0] OP_AND_I = 4'b1101;
    localparam logic [3:0] OP_XOR_X = 4'b1110;
    localparam logic [3:0] OP_XOR_I = 4'b1111;

    typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] hold_q;
    logic [IW-1:0] cand;
    logic [3:0]    op;
    logic [DW-1:0] opnd;
    logic [AW-1:0] n;
    logic          reg_op, rd_x, rd_acc, range_err, hazard;
    logic          issue, latch;

    logic          nxt_ov, nxt_is, nxt_as, nxt_err;
    logic [DW-1:0] nxt_d1, nxt_d2;
    logic [3:0]    nxt_op;
    logic [AW-1:0] nxt_iw;

    // Instruction under decode: the held one while stalled, else the input
    assign cand    = (state_q == ST_STALL) ? hold_q : INST;
    assign op      = cand[IW-1:DW];
    assign opnd    = cand[DW-1:0];
    assign n       = opnd[AW-1:0];
    assign IR_ADDR = n;
    assign IN_READY = (state_q == ST_RUN) && !RST;

    // Operand-source classification
    always_comb begin
        reg_op = 1'b0;
        rd_x   = 1'b0;
        rd_acc = 1'b0;
        case (op)
            OP_LDX: begin
                reg_op = 1'b1;
                rd_x   = 1'b1;
            end
            OP_STX: begin
                reg_op = 1'b1;
                rd_acc = 1'b1;
            end
            OP_ADD_X, OP_SUB_X, OP_OR_X, OP_AND_X, OP_XOR_X: begin
                reg_op = 1'b1;
                rd_x   = 1'b1;
                rd_acc = 1'b1;
            end
            OP_ADD_I, OP_SUB_I, OP_OR_I, OP_AND_I, OP_XOR_I, OP_NOT_A: begin
                rd_acc = 1'b1;
            end
            default: ;
        endcase
    end

    // Out-of-range accesses touch no register, so they never need to wait
    assign range_err = reg_op && (32'(n) >= NREG);
    assign hazard    = !range_err &&
                       ((rd_acc && AS) || (rd_x && IS && (IW_ADDR == n)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (IN_VALID && hazard) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Issue decision and operand routing; a bubble keeps data/address/op fields
    always_comb begin
        issue   = 1'b0;
        latch   = 1'b0;
        nxt_ov  = 1'b0;
        nxt_is  = 1'b0;
        nxt_as  = 1'b0;
        nxt_err = 1'b0;
        nxt_d1  = DATA1;
        nxt_d2  = DATA2;
        nxt_op  = ALU_OP;
        nxt_iw  = IW_ADDR;
        case (state_q)
            ST_RUN: begin
                issue = IN_VALID && !hazard;
                latch = IN_VALID && hazard;
            end
            ST_STALL: issue = 1'b1;
            default: ;
        endcase
        if (issue) begin
            nxt_ov  = 1'b1;
            nxt_err = range_err;
            nxt_op  = op;
            nxt_d1  = '0;
            nxt_d2  = '0;
            nxt_iw  = '0;
            case (op)
                OP_LDI, OP_NOT_I: nxt_d1 = opnd;
                OP_LDX:           nxt_d1 = INDEX;
                OP_STX: begin
                    nxt_d1 = ACC;
                    nxt_iw = n;
                end
                OP_ADD_X, OP_SUB_X, OP_OR_X, OP_AND_X, OP_XOR_X: begin
                    nxt_d1 = INDEX;
                    nxt_d2 = ACC;
                end
                OP_ADD_I, OP_SUB_I, OP_OR_I, OP_AND_I, OP_XOR_I: begin
                    nxt_d1 = ACC;
                    nxt_d2 = opnd;
                end
                OP_NOT_A:         nxt_d1 = ACC;
                default: ;
            endcase
            nxt_as = !range_err && (op != OP_NOP) && (op != OP_STX);
            nxt_is = !range_err && (op == OP_STX);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q    <= '0;
            OUT_VALID <= 1'b0;
            DATA1     <= '0;
            DATA2     <= '0;
            ALU_OP    <= '0;
            IW_ADDR   <= '0;
            IS        <= 1'b0;
            AS        <= 1'b0;
            ERR       <= 1'b0;
            INSN_CNT  <= '0;
        end else begin
            if (latch) hold_q <= INST;
            OUT_VALID <= nxt_ov;
            DATA1     <= nxt_d1;
            DATA2     <= nxt_d2;
            ALU_OP    <= nxt_op;
            IW_ADDR   <= nxt_iw;
            IS        <= nxt_is;
            AS        <= nxt_as;
            ERR       <= nxt_err;
            if (issue) INSN_CNT <= INSN_CNT + CW'(1);
        end
    end

endmodule

// File: tb/tb_ins_decode_pipe.sv
// Directed bench for ins_decode_pipe with a small execute-stage model (ACC and
// index file written one edge after issue) driving both decoder instances.
module tb_ins_decode_pipe;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instance A: default parameters
    logic       rst_a;
    logic [7:0] a_inst;
    logic       a_valid, a_ready;
    logic [3:0] acc_a, a_ir, a_index, a_d1, a_d2, a_op, a_iw;
    logic       a_is, a_as, a_ov, a_err;
    logic [15:0] a_cnt;
    logic [3:0] xa [16];

    // Instance B: NREG=12, CW=4
    logic       rst_b;
    logic [7:0] b_inst;
    logic       b_valid, b_ready;
    logic [3:0] acc_b, b_ir, b_index, b_d1, b_d2, b_op, b_iw;
    logic       b_is, b_as, b_ov, b_err;
    logic [3:0] b_cnt;
    logic [3:0] xb [16];

    assign a_index = xa[a_ir];
    assign b_index = xb[b_ir];

    ins_decode_pipe u_a (
        .CLK(CLK), .RST(rst_a), .INST(a_inst), .IN_VALID(a_valid), .IN_READY(a_ready),
        .ACC(acc_a), .IR_ADDR(a_ir), .INDEX(a_index), .DATA1(a_d1), .DATA2(a_d2),
        .ALU_OP(a_op), .IW_ADDR(a_iw), .IS(a_is), .AS(a_as), .OUT_VALID(a_ov),
        .ERR(a_err), .INSN_CNT(a_cnt)
    );

    ins_decode_pipe #(.DW(4), .NREG(12), .CW(4)) u_b (
        .CLK(CLK), .RST(rst_b), .INST(b_inst), .IN_VALID(b_valid), .IN_READY(b_ready),
        .ACC(acc_b), .IR_ADDR(b_ir), .INDEX(b_index), .DATA1(b_d1), .DATA2(b_d2),
        .ALU_OP(b_op), .IW_ADDR(b_iw), .IS(b_is), .AS(b_as), .OUT_VALID(b_ov),
        .ERR(b_err), .INSN_CNT(b_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] alu(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
        case (op)
            4'h1, 4'h2: return a;
            4'h4, 4'h5: return a + b;
            4'h6, 4'h7: return a - b;
            4'h8, 4'h9: return ~a;
            4'ha, 4'hb: return a | b;
            4'hc, 4'hd: return a & b;
            4'he, 4'hf: return a ^ b;
            default:    return a;
        endcase
    endfunction

    // One clock: execute stage consumes current outputs, writes land after the edge
    task automatic tick();
        logic       wa_a, wx_a, wa_b, wx_b;
        logic [3:0] va_a, vx_a, ix_a, va_b, vx_b, ix_b;
        wa_a = a_ov && a_as;  va_a = alu(a_op, a_d1, a_d2);
        wx_a = a_ov && a_is;  vx_a = a_d1;  ix_a = a_iw;
        wa_b = b_ov && b_as;  va_b = alu(b_op, b_d1, b_d2);
        wx_b = b_ov && b_is;  vx_b = b_d1;  ix_b = b_iw;
        @(posedge CLK);
        #1;
        if (wa_a) acc_a = va_a;
        if (wx_a) xa[ix_a] = vx_a;
        if (wa_b) acc_b = va_b;
        if (wx_b) xb[ix_b] = vx_b;
    endtask

    typedef struct {
        logic [7:0]  inst;
        logic        v;
        logic [3:0]  ir;
        logic        rdy, ov;
        logic [3:0]  d1, d2, op, iw;
        logic        wa, wi, err;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input int inst, input int v, input int ir, input int rdy,
                                input int ov, input int d1, input int d2, input int op,
                                input int iw, input int wa, input int wi, input int err,
                                input int cnt);
        vec_t t;
        t.inst = 8'(inst); t.v = 1'(v); t.ir = 4'(ir); t.rdy = 1'(rdy); t.ov = 1'(ov);
        t.d1 = 4'(d1); t.d2 = 4'(d2); t.op = 4'(op); t.iw = 4'(iw);
        t.wa = 1'(wa); t.wi = 1'(wi); t.err = 1'(err); t.cnt = 16'(cnt);
        return t;
    endfunction

    vec_t tbl [22];

    initial begin
        //           inst  v  ir  rdy ov d1 d2 op  iw as is err cnt
        tbl[0]  = mk('h15, 1, 5,  1, 1, 5, 0, 1,  0, 1, 0, 0, 1);
        tbl[1]  = mk('h13, 1, 3,  1, 1, 3, 0, 1,  0, 1, 0, 0, 2);
        tbl[2]  = mk('h52, 1, 2,  0, 0, 3, 0, 1,  0, 0, 0, 0, 2);
        tbl[3]  = mk('h07, 0, 2,  1, 1, 3, 2, 5,  0, 1, 0, 0, 3);
        tbl[4]  = mk('h00, 0, 0,  1, 0, 3, 2, 5,  0, 0, 0, 0, 3);
        tbl[5]  = mk('h19, 1, 9,  1, 1, 9, 0, 1,  0, 1, 0, 0, 4);
        tbl[6]  = mk('h00, 0, 0,  1, 0, 9, 0, 1,  0, 0, 0, 0, 4);
        tbl[7]  = mk('h34, 1, 4,  1, 1, 9, 0, 3,  4, 0, 1, 0, 5);
        tbl[8]  = mk('h24, 1, 4,  0, 0, 9, 0, 3,  4, 0, 0, 0, 5);
        tbl[9]  = mk('h07, 0, 4,  1, 1, 9, 0, 2,  0, 1, 0, 0, 6);
        tbl[10] = mk('h00, 0, 0,  1, 0, 9, 0, 2,  0, 0, 0, 0, 6);
        tbl[11] = mk('h34, 1, 4,  1, 1, 9, 0, 3,  4, 0, 1, 0, 7);
        tbl[12] = mk('h25, 1, 5,  1, 1, 5, 0, 2,  0, 1, 0, 0, 8);
        tbl[13] = mk('h64, 1, 4,  0, 0, 5, 0, 2,  0, 0, 0, 0, 8);
        tbl[14] = mk('h00, 0, 4,  1, 1, 9, 5, 6,  0, 1, 0, 0, 9);
        tbl[15] = mk('h00, 0, 0,  1, 0, 9, 5, 6,  0, 0, 0, 0, 9);
        tbl[16] = mk('hB3, 1, 3,  1, 1, 4, 3, 11, 0, 1, 0, 0, 10);
        tbl[17] = mk('h9A, 1, 10, 1, 1, 10, 0, 9, 0, 1, 0, 0, 11);
        tbl[18] = mk('h80, 1, 0,  0, 0, 10, 0, 9, 0, 0, 0, 0, 11);
        tbl[19] = mk('h07, 0, 0,  1, 1, 5, 0, 8,  0, 1, 0, 0, 12);
        tbl[20] = mk('h00, 1, 0,  1, 1, 0, 0, 0,  0, 0, 0, 0, 13);
        tbl[21] = mk('h15, 0, 5,  1, 0, 0, 0, 0,  0, 0, 0, 0, 13);

        rst_a = 1'b1; rst_b = 1'b1;
        a_inst = '0; a_valid = 1'b0; acc_a = '0;
        b_inst = '0; b_valid = 1'b0; acc_b = '0;
        for (int i = 0; i < 16; i++) begin
            xa[i] = 4'(i);
            xb[i] = 4'(i);
        end
        tick();
        tick();
        chk("reset ov", 32'(a_ov), 0);
        chk("reset d1", 32'(a_d1), 0);
        chk("reset as", 32'(a_as), 0);
        chk("reset cnt", 32'(a_cnt), 0);
        chk("reset ready low in reset", 32'(a_ready), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("ready after reset", 32'(a_ready), 1);

        // Main table on instance A
        for (int i = 0; i < 22; i++) begin
            a_inst  = tbl[i].inst;
            a_valid = tbl[i].v;
            #1;
            chk($sformatf("row%0d ir_addr", i), 32'(a_ir), 32'(tbl[i].ir));
            tick();
            chk($sformatf("row%0d in_ready", i), 32'(a_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d out_valid", i), 32'(a_ov), 32'(tbl[i].ov));
            chk($sformatf("row%0d data1", i), 32'(a_d1), 32'(tbl[i].d1));
            chk($sformatf("row%0d data2", i), 32'(a_d2), 32'(tbl[i].d2));
            chk($sformatf("row%0d alu_op", i), 32'(a_op), 32'(tbl[i].op));
            chk($sformatf("row%0d iw_addr", i), 32'(a_iw), 32'(tbl[i].iw));
            chk($sformatf("row%0d as", i), 32'(a_as), 32'(tbl[i].wa));
            chk($sformatf("row%0d is", i), 32'(a_is), 32'(tbl[i].wi));
            chk($sformatf("row%0d err", i), 32'(a_err), 32'(tbl[i].err));
            chk($sformatf("row%0d insn_cnt", i), 32'(a_cnt), 32'(tbl[i].cnt));
        end

        // Reset while stalled discards the held instruction
        a_inst = 8'h15; a_valid = 1'b1;
        tick();
        chk("pre-stall cnt", 32'(a_cnt), 14);
        a_inst = 8'h52;
        tick();
        chk("stall ready", 32'(a_ready), 0);
        chk("stall bubble", 32'(a_ov), 0);
        a_valid = 1'b0;
        rst_a = 1'b1;
        #1;
        chk("rst-in-stall ov", 32'(a_ov), 0);
        chk("rst-in-stall data1", 32'(a_d1), 0);
        chk("rst-in-stall alu_op", 32'(a_op), 0);
        chk("rst-in-stall as", 32'(a_as), 0);
        chk("rst-in-stall cnt", 32'(a_cnt), 0);
        tick();
        rst_a = 1'b0;
        #1;
        chk("rst-in-stall ready after", 32'(a_ready), 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("held discarded ov%0d", i), 32'(a_ov), 0);
            chk($sformatf("held discarded cnt%0d", i), 32'(a_cnt), 0);
        end

        // Instance B: 4-bit counter wrap on a NOP stream
        b_inst = 8'h00; b_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("nop%0d cnt", i + 1), 32'(b_cnt), 32'((i + 1) % 16));
            chk($sformatf("nop%0d ov", i + 1), 32'(b_ov), 1);
            chk($sformatf("nop%0d as|is", i + 1), 32'(b_as | b_is), 0);
        end

        // Instance B: out-of-range LDX, then an ACC reader must not stall
        b_inst = 8'h2E;
        tick();
        chk("range ov", 32'(b_ov), 1);
        chk("range err", 32'(b_err), 1);
        chk("range as", 32'(b_as), 0);
        chk("range is", 32'(b_is), 0);
        chk("range cnt", 32'(b_cnt), 2);
        chk("range ready", 32'(b_ready), 1);
        b_inst = 8'h52;
        tick();
        chk("after range ov", 32'(b_ov), 1);
        chk("after range err", 32'(b_err), 0);
        chk("after range as", 32'(b_as), 1);
        chk("after range data1", 32'(b_d1), 0);
        chk("after range data2", 32'(b_d2), 2);
        chk("after range cnt", 32'(b_cnt), 3);
        b_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ins_decode_pipe.md
Name: ins_decode_pipe

Overview:
- Parametrised, hazard-aware successor to the toy-CPU instruction decoder.
- Accepts one instruction per cycle over a valid/ready handshake and reads the index register file through its own address port.
- Emits registered operand, ALU-op and write-strobe controls to the execute stage.
- Inserts a one-cycle bubble when an instruction would read a stale accumulator or a stale index register, so software needs no NOP padding.

Parameters:
- DW, 4, data width; also the width of the instruction operand field. The instruction word is 4+DW bits.
- NREG, 16, number of index registers; must satisfy 2 <= NREG <= 2**DW.
- AW, clog2(NREG), index register address width; derived, not overridable.
- CW, 16, width of the issued-instruction counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- INST  in  4+DW  instruction: opcode [DW+3:DW], operand [DW-1:0].
- IN_VALID  in  1  INST is valid.
- IN_READY  out  1  decoder accepts INST this cycle.
- ACC  in  DW  current accumulator value.
- IR_ADDR  out  AW  index register read address (combinational).
- INDEX  in  DW  index register read data for IR_ADDR (combinational file).
- DATA1  out  DW  ALU operand 1.
- DATA2  out  DW  ALU operand 2.
- ALU_OP  out  4  opcode passed to the ALU.
- IW_ADDR  out  AW  index register write address.
- IS  out  1  index register write strobe.
- AS  out  1  accumulator write strobe.
- OUT_VALID  out  1  outputs carry an issued instruction.
- ERR  out  1  issued instruction addressed a register >= NREG.
- INSN_CNT  out  CW  count of issued instructions.

Behaviour:
- Opcode map:
  - 0000 NOP.
  - 0001 LDI: ACC <= imm.
  - 0010 LDX: ACC <= X[n].
  - 0011 STX: X[n] <= ACC.
  - 0100/0110/1010/1100/1110 ADD/SUB/OR/AND/XOR using X[n] and ACC.
  - 0101/0111/1011/1101/1111 the same operations using ACC and imm.
  - 1000 NOT ACC.
  - 1001 NOT imm.
  - imm = operand; n = operand[AW-1:0]. Operand bits above AW are ignored for register ops.
- Operand routing:
  - LDI and NOT imm: DATA1=imm.
  - LDX: DATA1=INDEX.
  - STX: DATA1=ACC, IW_ADDR=n, IS=1.
  - Register ALU ops: DATA1=INDEX, DATA2=ACC.
  - Immediate ALU ops: DATA1=ACC, DATA2=imm.
  - NOT ACC: DATA1=ACC.
  - Every opcode except NOP and STX: AS=1.
  - Unused fields drive 0 (never Z).
  - ALU_OP = opcode.
- Execute-stage timing: outputs registered at edge k are consumed during cycle k. ACC and index writes land at edge k+1.
- Reads:
  - ACC and INDEX are sampled at the issuing edge.
  - IR_ADDR = n of the instruction being decoded: the INST operand in RUN, the held operand in STALL.
- Hazard: the candidate instruction hazards against the last issued instruction (OUT_VALID=1) when either:
  - it reads ACC (STX, all ALU-ACC ops, NOT ACC) and the last issued instruction had AS=1; or
  - it reads X[n] (LDX, register ALU ops) and the last issued instruction had IS=1 with IW_ADDR==n.
  - A bubble clears the last-issued record.
- FSM states: RUN and STALL.
- RUN: IN_READY=1. On IN_VALID:
  - No hazard: issue at the next edge with OUT_VALID=1 and INSN_CNT+1.
  - Hazard: latch INST into the hold register and enter STALL. Outputs that edge form a bubble: OUT_VALID=0, IS=AS=ERR=0; DATA/ADDR/ALU_OP keep their previous values.
- RUN with no IN_VALID: bubble.
- STALL: IN_READY=0. At the next edge, issue the held instruction with freshly sampled ACC/INDEX and return to RUN. Stall is always exactly one cycle.
- Range error: if a register op has operand[AW-1:0] >= NREG (possible only for non-power-of-2 NREG):
  - issue with OUT_VALID=1, ERR=1, IS=AS=0;
  - it counts toward INSN_CNT;
  - it does not create a hazard.
- NOP: issues with OUT_VALID=1, IS=AS=0; counts.
- INSN_CNT wraps modulo 2**CW.
- Reset:
  - All registered outputs and INSN_CNT go to 0, the last-issued record is cleared, and the FSM goes to RUN.
  - IN_READY=1 while RST is deasserted.
  - Reset asserted in STALL discards the held instruction.
- Throughput is 1 instruction/cycle when there is no hazard. A back-to-back dependency costs one bubble.

Test Plan:
- DW=4, INST=0x15, IN_VALID one cycle -> next cycle OUT_VALID=1, DATA1=5, DATA2=0, ALU_OP=1, AS=1, IS=0, INSN_CNT=1.
- 0x13 then 0x52 back-to-back, with a model ACC updated one edge after issue -> IN_READY=0 for one cycle, then one bubble, then ADD issues with DATA1=3, DATA2=2. Total 3 cycles for 2 instructions.
- ACC=9, 0x34 then 0x24 -> bubble, then LDX issues with IR_ADDR=4, DATA1=9 from the updated file. Sequence 0x34 then 0x25 -> no bubble.
- NREG=12, INST=0x2E -> OUT_VALID=1, ERR=1, AS=0, IS=0, INSN_CNT incremented. A following ACC-reading op issues without a stall.
- Assert RST on the cycle after a hazard enters STALL -> all outputs 0, IN_READY=1 after release, held instruction never issues, INSN_CNT=0.
- CW=4, 17 NOPs streamed -> INSN_CNT reads 0 after the 16th issue and 1 after the 17th. IS and AS stay 0 throughout.
